// File: rtl/mmio_timer.sv
// mmio_timer -- memory-mapped prescaled timer peripheral on the LSU data port.
//
// Register map (i_addr[3:2]):
//   0 CTRL    [0] en, [1] auto_reload, [2] irq_en, [8 +: PRESCALE_W] prescale
//   1 COUNT   32-bit up-counter, read/write
//   2 COMPARE 32-bit compare value, read/write
//   3 STATUS  [0] sticky match flag, write 1 to bit 0 to clear
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_sel       region select from LSU address decode
//   i_wren      store request
//   i_rden      load request
//   i_addr      byte offset; [3:2] selects register, [1:0] ignored
//   i_wdata     store data
//   i_bytemask  per-byte write enables
//   o_rdata     registered load data, 0 when no load was issued
//   o_irq       interrupt level (flag & irq_en)

module mmio_timer #(
    parameter int          PRESCALE_W  = 8,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic        i_wren,
    input  logic        i_rden,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_bytemask,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_COUNT   = 2'd1;
    localparam logic [1:0] ADDR_COMPARE = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_flag;
    logic [31:0]           r_rdata;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wr_ctrl;
    logic                  w_wr_count;
    logic                  w_wr_compare;
    logic                  w_w1c;
    logic                  w_tick;
    logic                  w_match;
    logic                  w_en_nxt;
    logic [PRESCALE_W-1:0] w_prescale_wr;
    logic [31:0]           w_ctrl;
    logic [31:0]           w_rmux;
    logic                  w_unused;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = mask[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign w_unused     = ^i_addr[1:0];

    assign w_wr         = i_sel & i_wren;
    assign w_rd         = i_sel & i_rden;
    assign w_wr_ctrl    = w_wr & (i_addr[3:2] == ADDR_CTRL);
    assign w_wr_count   = w_wr & (i_addr[3:2] == ADDR_COUNT);
    assign w_wr_compare = w_wr & (i_addr[3:2] == ADDR_COMPARE);
    assign w_w1c        = w_wr & (i_addr[3:2] == ADDR_STATUS) & i_bytemask[0] & i_wdata[0];

    assign w_tick       = r_en & (r_pcnt == r_prescale);
    assign w_match      = r_count == r_compare;

    // en as it will be after this edge; clearing en zeroes pcnt on the same edge
    assign w_en_nxt     = (w_wr_ctrl & i_bytemask[0]) ? i_wdata[0] : r_en;

    // prescale field may straddle byte lanes, so pick each bit by its own lane
    always_comb begin
        w_prescale_wr = r_prescale;
        for (int i = 0; i < PRESCALE_W; i++) begin
            if (i_bytemask[(8 + i) / 8]) begin
                w_prescale_wr[i] = i_wdata[8 + i];
            end
        end
    end

    always_comb begin
        w_ctrl                  = '0;
        w_ctrl[0]               = r_en;
        w_ctrl[1]               = r_auto;
        w_ctrl[2]               = r_irq_en;
        w_ctrl[8 +: PRESCALE_W] = r_prescale;
    end

    always_comb begin
        w_rmux = '0;
        case (i_addr[3:2])
            ADDR_CTRL:    w_rmux = w_ctrl;
            ADDR_COUNT:   w_rmux = r_count;
            ADDR_COMPARE: w_rmux = r_compare;
            ADDR_STATUS:  w_rmux = {31'b0, r_flag};
            default:      w_rmux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_count    <= '0;
            r_compare  <= COMPARE_RST;
            r_flag     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_wr_ctrl) begin
                if (i_bytemask[0]) begin
                    r_en     <= i_wdata[0];
                    r_auto   <= i_wdata[1];
                    r_irq_en <= i_wdata[2];
                end
                r_prescale <= w_prescale_wr;
            end

            if (!r_en || !w_en_nxt || w_tick) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end

            // a CPU write to COUNT suppresses both increment and compare
            if (w_wr_count) begin
                r_count <= merge_bytes(r_count, i_wdata, i_bytemask);
            end else if (w_tick) begin
                if (w_match && r_auto) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 32'd1;
                end
            end

            if (w_wr_compare) begin
                r_compare <= merge_bytes(r_compare, i_wdata, i_bytemask);
            end

            // tick-driven set wins over a simultaneous W1C
            if (w_tick && w_match && !w_wr_count) begin
                r_flag <= 1'b1;
            end else if (w_w1c) begin
                r_flag <= 1'b0;
            end

            r_rdata <= w_rd ? w_rmux : 32'd0;
        end
    end

    assign o_rdata = r_rdata;
    assign o_irq   = r_flag & r_irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        wren;
    logic        rden;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  bytemask;
    logic [31:0] o_rdata;
    logic        o_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mmio_timer #(
        .PRESCALE_W  (8),
        .COMPARE_RST (32'hFFFF_FFFF)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sel      (sel),
        .i_wren     (wren),
        .i_rden     (rden),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .i_bytemask (bytemask),
        .o_rdata    (o_rdata),
        .o_irq      (o_irq)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        sel = 1'b1; wren = 1'b1; addr = a; wdata = d; bytemask = m;
        cyc();
        sel = 1'b0; wren = 1'b0; wdata = '0; bytemask = '0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
        sel = 1'b1; rden = 1'b1; addr = a;
        cyc();
        sel = 1'b0; rden = 1'b0;
        chk(tag, o_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; wren = 1'b0; rden = 1'b0;
        addr = '0; wdata = '0; bytemask = '0;
        cyc(); cyc();
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_irq", {31'b0, o_irq}, 32'd0);
        rst = 1'b0;

        // reset values of all registers
        rd(4'h0, 32'h0000_0000, "rst_ctrl");
        rd(4'h4, 32'h0000_0000, "rst_count");
        rd(4'h8, 32'hFFFF_FFFF, "rst_compare");
        rd(4'hC, 32'h0000_0000, "rst_status");
        cyc();
        chk("idle_rdata_zero", o_rdata, 32'd0);

        // prescale 0, auto-reload, irq enabled; match at COUNT=5
        wr(4'h8, 32'd5, 4'hF);
        wr(4'h0, 32'h0000_0007, 4'hF);
        for (int k = 0; k < 6; k++) begin
            rd(4'h4, 32'(k), "count_seq");
            chk("irq_seq", {31'b0, o_irq}, (k == 5) ? 32'd1 : 32'd0);
        end
        rd(4'h4, 32'd0, "count_reload");
        rd(4'hC, 32'd1, "flag_sticky");

        // reset while counting, with a load pending in the same cycle
        rst = 1'b1; sel = 1'b1; rden = 1'b1; addr = 4'h4;
        cyc();
        rst = 1'b0; sel = 1'b0; rden = 1'b0;
        chk("midrst_rdata", o_rdata, 32'd0);
        chk("midrst_irq", {31'b0, o_irq}, 32'd0);
        rd(4'h4, 32'd0, "midrst_count");
        rd(4'h0, 32'd0, "midrst_ctrl");

        // W1C coinciding with a matching tick, then W1C alone
        wr(4'h8, 32'd2, 4'hF);
        wr(4'h0, 32'h0000_0007, 4'hF);
        cyc(); cyc();
        wr(4'hC, 32'd1, 4'h1);
        chk("w1c_vs_tick_irq", {31'b0, o_irq}, 32'd1);
        wr(4'hC, 32'd1, 4'h1);
        chk("w1c_clear_irq", {31'b0, o_irq}, 32'd0);
        rd(4'hC, 32'd0, "w1c_clear_flag");
        wr(4'h0, 32'h0000_0000, 4'hF);

        // prescale 3: one increment every 4 cycles, freeze and restart
        rst = 1'b1; cyc(); rst = 1'b0;
        wr(4'h0, 32'h0000_0301, 4'hF);
        cyc(); cyc();
        rd(4'h4, 32'd0, "psc_before");
        rd(4'h4, 32'd0, "psc_edge");
        rd(4'h4, 32'd1, "psc_first");
        wr(4'h0, 32'h0000_0300, 4'hF);
        for (int k = 0; k < 6; k++) cyc();
        rd(4'h4, 32'd1, "psc_frozen");
        wr(4'h0, 32'h0000_0301, 4'hF);
        cyc(); cyc();
        rd(4'h4, 32'd1, "psc_restart_a");
        rd(4'h4, 32'd1, "psc_restart_b");
        rd(4'h4, 32'd2, "psc_restart_inc");
        wr(4'h0, 32'h0000_0000, 4'hF);

        // wrap without match, no auto-reload
        rst = 1'b1; cyc(); rst = 1'b0;
        wr(4'h8, 32'd7, 4'hF);
        wr(4'h4, 32'hFFFF_FFFE, 4'hF);
        wr(4'h0, 32'h0000_0001, 4'hF);
        rd(4'h4, 32'hFFFF_FFFE, "wrap_a");
        rd(4'h4, 32'hFFFF_FFFF, "wrap_b");
        rd(4'h4, 32'h0000_0000, "wrap_zero");
        wr(4'h0, 32'h0000_0000, 4'hF);
        rd(4'hC, 32'd0, "wrap_noflag");

        // byte-masked writes
        wr(4'h4, 32'h1234_5678, 4'hF);
        wr(4'h4, 32'h0000_00AB, 4'h1);
        rd(4'h4, 32'h1234_56AB, "byte_lane0");
        wr(4'h4, 32'h0000_BEEF, 4'h3);
        rd(4'h4, 32'h1234_BEEF, "half_lane01");
        wr(4'h0, 32'h0000_5A00, 4'h2);
        rd(4'h0, 32'h0000_5A00, "ctrl_prescale");
        wr(4'h0, 32'hFFFF_FFF8, 4'hF);
        rd(4'h0, 32'h0000_FF00, "ctrl_rsvd_zero");

        // simultaneous load and store
        sel = 1'b1; rden = 1'b1; wren = 1'b1; addr = 4'h4;
        wdata = 32'hCAFE_F00D; bytemask = 4'hF;
        cyc();
        sel = 1'b0; rden = 1'b0; wren = 1'b0; wdata = '0; bytemask = '0;
        chk("rw_old", o_rdata, 32'h1234_BEEF);
        rd(4'h4, 32'hCAFE_F00D, "rw_new");

        // access with sel low is ignored
        sel = 1'b0; rden = 1'b1; wren = 1'b1; addr = 4'h4;
        wdata = 32'h0000_0000; bytemask = 4'hF;
        cyc();
        rden = 1'b0; wren = 1'b0; bytemask = '0;
        chk("nosel_rdata", o_rdata, 32'd0);
        rd(4'h4, 32'hCAFE_F00D, "nosel_count");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
